// File: rtl/commit_arb_pkg.sv
// Shared types and helpers for the commit writeback arbiter.
// Sizing (NUM_REQS, DATAW) lives here so the beat struct and the arbiter agree.
package commit_arb_pkg;

  localparam int NUM_REQS = 5;
  localparam int DATAW    = 64;
  localparam int SEL_W    = $clog2(NUM_REQS);

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic             eop;
    logic [SEL_W-1:0] sel;
  } wb_beat_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // First valid requester at or after ptr, wrapping modulo NUM_REQS.
  // With nothing valid the pointer itself is returned.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQS-1:0] valid,
                                               input logic [SEL_W-1:0]    ptr);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = SEL_W'((int'(ptr) + k) % NUM_REQS);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/commit_skid_buf.sv
// Two-entry elastic buffer of writeback beats; output is always a registered head
// entry, so a push into an empty buffer shows up one cycle later.
module commit_skid_buf
  import commit_arb_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     in_valid,
  output logic     in_ready,
  input  wb_beat_t in_beat,
  output logic     out_valid,
  input  logic     out_ready,
  output wb_beat_t out_beat
);

  wb_beat_t   mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // Full buffer still accepts when the head leaves in the same cycle.
  assign in_ready  = !reset && ((count != 2'd2) || out_ready);
  assign out_valid = (count != 2'd0);
  assign out_beat  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/commit_wb_arbiter.sv
// Round-robin arbiter sharing the register-file writeback port between commit sources,
// with packet locking and a 2-entry skid buffer. Optional stall counters: COMMIT_ARB_PERF_EN.
//
// state      | meaning
// ARB_OPEN   | no packet in flight; grant follows round-robin from rr_ptr
// ARB_LOCKED | a multi-beat packet is in flight; grant stays on lock_idx until its eop
module commit_wb_arbiter
  import commit_arb_pkg::*;
`ifdef COMMIT_ARB_PERF_EN
#(
  parameter int PERF_W = 32
)
`endif
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS-1:0]       req_eop,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [DATAW-1:0]          wb_data,
  output logic                      wb_eop,
  output logic [SEL_W-1:0]          wb_sel
`ifdef COMMIT_ARB_PERF_EN
  ,
  output logic [NUM_REQS*PERF_W-1:0] perf_stalls
`endif
);

  arb_state_t       state, state_nx;
  logic [SEL_W-1:0] lock_idx, lock_idx_nx;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_nx;
  logic [SEL_W-1:0] grant;
  logic             in_ready;
  logic             xfer;
  wb_beat_t         in_beat;
  wb_beat_t         out_beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_OPEN;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nx;
      lock_idx <= lock_idx_nx;
      rr_ptr   <= rr_ptr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    lock_idx_nx = lock_idx;
    rr_ptr_nx   = rr_ptr;
    req_ready   = '0;
    grant       = (state == ARB_LOCKED) ? lock_idx : rr_pick(req_valid, rr_ptr);
    xfer        = req_valid[grant] && in_ready;
    if (in_ready) begin
      req_ready[grant] = 1'b1;
    end
    if (xfer) begin
      if (req_eop[grant]) begin
        state_nx  = ARB_OPEN;
        rr_ptr_nx = (grant == SEL_W'(NUM_REQS - 1)) ? '0 : grant + SEL_W'(1);
      end else begin
        state_nx    = ARB_LOCKED;
        lock_idx_nx = grant;
      end
    end
  end

  always_comb begin
    in_beat.data = req_data[int'(grant)*DATAW +: DATAW];
    in_beat.eop  = req_eop[grant];
    in_beat.sel  = grant;
  end

  commit_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (req_valid[grant]),
    .in_ready  (in_ready),
    .in_beat   (in_beat),
    .out_valid (wb_valid),
    .out_ready (wb_ready),
    .out_beat  (out_beat)
  );

  assign wb_data = out_beat.data;
  assign wb_eop  = out_beat.eop;
  assign wb_sel  = out_beat.sel;

`ifdef COMMIT_ARB_PERF_EN
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_perf
    logic [PERF_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
      end else if (req_valid[i] && !req_ready[i] && !(&cnt)) begin
        cnt <= cnt + PERF_W'(1);
      end
    end
    assign perf_stalls[i*PERF_W +: PERF_W] = cnt;
  end
`endif

endmodule
